// File: rtl/sevenseg_pkg.sv
// Shared types and sizing helpers for the seven-segment scan controller.
package sevenseg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int DIGIT_W = 4;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Refresh-slot prescaler: counts 0..REFRESH_DIV-1 while run is high, cleared otherwise.
module scan_prescaler
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tc
);

  localparam int CW = (REFRESH_DIV <= 2) ? 1 : $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count_r;

  // Slot counter, wrapping at the terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (!run) begin
      count_r <= {CW{1'b0}};
    end else if (count_r == LAST_CNT) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tc = run && (count_r == LAST_CNT);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed hex display scanner with double-buffered value and leading-zero blanking.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [DIGIT_W-1:0]            binaryout,
  output logic                          decout,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_done
);

  localparam int IW = idx_w(NUM_DIGITS);
  localparam int VW = DIGIT_W * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_t           state_r;
  logic [IW-1:0]         idx_r;
  logic [VW-1:0]         pend_val_r;
  logic [NUM_DIGITS-1:0] pend_dp_r;
  logic                  pend_valid_r;
  logic [VW-1:0]         disp_val_r;
  logic [NUM_DIGITS-1:0] disp_dp_r;

  logic                  run_s;
  logic                  tc_s;
  logic                  boundary_s;
  logic                  blank_s;
  logic [VW-1:0]         upper_val_s;
  logic [NUM_DIGITS-1:0] upper_dp_s;
  logic [NUM_DIGITS-1:0] onehot_s;

  assign run_s      = (state_r == SCAN) && enable;
  assign boundary_s = tc_s && (idx_r == LAST_IDX);
  assign onehot_s   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;

  scan_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (run_s),
    .tc   (tc_s)
  );

  // A digit is a leading zero when it and every more-significant digit and dp are clear.
  always_comb begin
    upper_val_s = disp_val_r >> {idx_r, 2'b00};
    upper_dp_s  = disp_dp_r >> idx_r;
    if ((BLANK_LEADING != 0) && (idx_r != {IW{1'b0}}) &&
        (upper_val_s == {VW{1'b0}}) && (upper_dp_s == {NUM_DIGITS{1'b0}})) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
  end

  // Scan FSM, buffers and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      idx_r        <= {IW{1'b0}};
      pend_val_r   <= {VW{1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_valid_r <= 1'b0;
      disp_val_r   <= {VW{1'b0}};
      disp_dp_r    <= {NUM_DIGITS{1'b0}};
      binaryout    <= {DIGIT_W{1'b0}};
      decout       <= 1'b0;
      digit_en     <= {NUM_DIGITS{1'b0}};
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          idx_r     <= {IW{1'b0}};
          binaryout <= {DIGIT_W{1'b0}};
          decout    <= 1'b0;
          digit_en  <= {NUM_DIGITS{1'b0}};
          if (enable) begin
            state_r <= SCAN;
            if (pend_valid_r) begin
              disp_val_r   <= pend_val_r;
              disp_dp_r    <= pend_dp_r;
              pend_valid_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (!enable) begin
            state_r   <= IDLE;
            idx_r     <= {IW{1'b0}};
            binaryout <= {DIGIT_W{1'b0}};
            decout    <= 1'b0;
            digit_en  <= {NUM_DIGITS{1'b0}};
          end else begin
            state_r <= SCAN;
            if (tc_s) begin
              idx_r <= (idx_r == LAST_IDX) ? {IW{1'b0}} : idx_r + {{(IW-1){1'b0}}, 1'b1};
            end
            if (boundary_s) begin
              frame_done <= 1'b1;
              if (pend_valid_r) begin
                disp_val_r   <= pend_val_r;
                disp_dp_r    <= pend_dp_r;
                pend_valid_r <= 1'b0;
              end
            end
            if (blank_s) begin
              binaryout <= {DIGIT_W{1'b0}};
              decout    <= 1'b0;
              digit_en  <= {NUM_DIGITS{1'b0}};
            end else begin
              binaryout <= disp_val_r[idx_r*DIGIT_W +: DIGIT_W];
              decout    <= disp_dp_r[idx_r];
              digit_en  <= onehot_s;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          idx_r    <= {IW{1'b0}};
          digit_en <= {NUM_DIGITS{1'b0}};
        end
      endcase
      // A load overrides any clear above, so a boundary-cycle load waits a frame.
      if (load) begin
        pend_val_r   <= value_in;
        pend_dp_r    <= dp_in;
        pend_valid_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  binaryout, binaryout_nb;
  logic        decout, decout_nb;
  logic [3:0]  digit_en, digit_en_nb;
  logic        frame_done, frame_done_nb;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  typedef struct {
    int          step;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  e_den;
    logic [3:0]  e_bin;
    logic        e_dec;
    logic        e_fd;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .value_in(value_in), .dp_in(dp_in),
    .binaryout(binaryout), .decout(decout),
    .digit_en(digit_en), .frame_done(frame_done)
  );

  sevenseg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(0)) u_nob (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .value_in(value_in), .dp_in(dp_in),
    .binaryout(binaryout_nb), .decout(decout_nb),
    .digit_en(digit_en_nb), .frame_done(frame_done_nb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%h expected=%h", nm, step_no, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] den, input logic [3:0] bin,
                         input logic dec, input logic fd);
    chk({nm, ".digit_en"}, {12'h000, digit_en}, {12'h000, den});
    chk({nm, ".binaryout"}, {12'h000, binaryout}, {12'h000, bin});
    chk({nm, ".decout"}, {15'h0000, decout}, {15'h0000, dec});
    chk({nm, ".frame_done"}, {15'h0000, frame_done}, {15'h0000, fd});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; load = 1'b0; value_in = 16'h0000; dp_in = 4'b0000;

    // Reset held three cycles with enable high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rst", 4'b0000, 4'h0, 1'b0, 1'b0);
      chk("rst.nob_den", {12'h000, digit_en_nb}, 16'h0000);
    end
    reset = 1'b0;
    step_no = 0;

    // First frame: one blank cycle, then 4-cycle slots; frame_done at step 17.
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] exp_den;
      tick();
      exp_den = (k == 1) ? 4'b0000 : (4'b0001 << (((k - 2) / 4) % 4));
      chk("scan.nob_den", {12'h000, digit_en_nb}, {12'h000, exp_den});
      chk("scan.frame_done", {15'h0000, frame_done}, {15'h0000, (k == 17)});
    end

    // Load/double-buffer/blanking vectors on the BLANK_LEADING=1 instance.
    tbl.push_back(vec_t'{22,  1'b1, 16'h12A7, 4'b0100, 4'b0000, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{26,  1'b0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{33,  1'b0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{34,  1'b0, 16'h0000, 4'b0000, 4'b0001, 4'h7, 1'b0, 1'b0});
    tbl.push_back(vec_t'{39,  1'b0, 16'h0000, 4'b0000, 4'b0010, 4'hA, 1'b0, 1'b0});
    tbl.push_back(vec_t'{42,  1'b0, 16'h0000, 4'b0000, 4'b0100, 4'h2, 1'b1, 1'b0});
    tbl.push_back(vec_t'{49,  1'b0, 16'h0000, 4'b0000, 4'b1000, 4'h1, 1'b0, 1'b1});
    tbl.push_back(vec_t'{52,  1'b1, 16'h0005, 4'b0000, 4'b0001, 4'h7, 1'b0, 1'b0});
    tbl.push_back(vec_t'{58,  1'b0, 16'h0000, 4'b0000, 4'b0100, 4'h2, 1'b1, 1'b0});
    tbl.push_back(vec_t'{66,  1'b0, 16'h0000, 4'b0000, 4'b0001, 4'h5, 1'b0, 1'b0});
    tbl.push_back(vec_t'{71,  1'b0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{75,  1'b0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{80,  1'b1, 16'h0000, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{83,  1'b0, 16'h0000, 4'b0000, 4'b0001, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{87,  1'b0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{88,  1'b1, 16'h1111, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{92,  1'b1, 16'h2222, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{98,  1'b0, 16'h0000, 4'b0000, 4'b0001, 4'h2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{103, 1'b0, 16'h0000, 4'b0000, 4'b0010, 4'h2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{107, 1'b0, 16'h0000, 4'b0000, 4'b0100, 4'h2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{111, 1'b0, 16'h0000, 4'b0000, 4'b1000, 4'h2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{113, 1'b1, 16'h3333, 4'b0000, 4'b1000, 4'h2, 1'b0, 1'b1});
    tbl.push_back(vec_t'{114, 1'b0, 16'h0000, 4'b0000, 4'b0001, 4'h2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{126, 1'b0, 16'h0000, 4'b0000, 4'b1000, 4'h2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{129, 1'b0, 16'h0000, 4'b0000, 4'b1000, 4'h2, 1'b0, 1'b1});
    tbl.push_back(vec_t'{130, 1'b0, 16'h0000, 4'b0000, 4'b0001, 4'h3, 1'b0, 1'b0});
    tbl.push_back(vec_t'{133, 1'b1, 16'h0000, 4'b1000, 4'b0001, 4'h3, 1'b0, 1'b0});
    tbl.push_back(vec_t'{150, 1'b0, 16'h0000, 4'b0000, 4'b0010, 4'h0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{158, 1'b0, 16'h0000, 4'b0000, 4'b1000, 4'h0, 1'b1, 1'b0});

    foreach (tbl[i]) begin
      while (step_no < tbl[i].step - 1) tick();
      if (tbl[i].ld) begin
        load = 1'b1; value_in = tbl[i].val; dp_in = tbl[i].dp;
      end
      tick();
      load = 1'b0;
      chk_all($sformatf("vec%0d", i), tbl[i].e_den, tbl[i].e_bin, tbl[i].e_dec, tbl[i].e_fd);
    end

    // Disable mid-slot of digit 2, load while idle, then re-enable.
    while (step_no < 171) tick();
    chk("pre_dis.digit_en", {12'h000, digit_en}, 16'h0004);
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        load = 1'b1; value_in = 16'h5678; dp_in = 4'b0001;
      end
      tick();
      load = 1'b0;
      chk("idle.digit_en", {12'h000, digit_en}, 16'h0000);
      chk("idle.frame_done", {15'h0000, frame_done}, 16'h0000);
    end
    enable = 1'b1;
    tick();
    chk_all("reen.blank", 4'b0000, 4'h0, 1'b0, 1'b0);
    tick();
    chk_all("reen.d0", 4'b0001, 4'h8, 1'b1, 1'b0);
    while (step_no < 186) tick();
    chk_all("reen.d1", 4'b0010, 4'h7, 1'b0, 1'b0);
    while (step_no < 196) tick();
    chk("reen.fd_early", {15'h0000, frame_done}, 16'h0000);
    tick();
    chk("reen.fd", {15'h0000, frame_done}, 16'h0001);

    // Reset in SCAN with a pending value that must be discarded.
    while (step_no < 199) tick();
    load = 1'b1; value_in = 16'h9ABC; dp_in = 4'b1111;
    tick();
    load = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk_all("rst2.a", 4'b0000, 4'h0, 1'b0, 1'b0);
    tick();
    chk_all("rst2.b", 4'b0000, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step_no = 0;
    tick();
    chk_all("post.blank", 4'b0000, 4'h0, 1'b0, 1'b0);
    tick();
    chk_all("post.d0", 4'b0001, 4'h0, 1'b0, 1'b0);
    while (step_no < 6) tick();
    chk_all("post.d1", 4'b0000, 4'h0, 1'b0, 1'b0);
    chk("post.nob_d1", {12'h000, digit_en_nb}, 16'h0002);
    while (step_no < 17) tick();
    chk("post.fd", {15'h0000, frame_done}, 16'h0001);
    tick();
    chk_all("post.f2d0", 4'b0001, 4'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
